// File: rtl/hp_pkg.sv
// Shared FSM encoding and overlay colours for the HP bar controller.
package hp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIVE  = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } hp_state_t;

    localparam logic [11:0] COL_FRAME = 12'hfff;
    localparam logic [11:0] COL_OK    = 12'h0f0;
    localparam logic [11:0] COL_LOW   = 12'hf00;
    localparam logic [11:0] COL_EMPTY = 12'h333;

endpackage

// File: rtl/hp_edge_det.sv
// Single-flop rising-edge detector; the edge pulse is combinational from the
// live input and the registered history.
module hp_edge_det (
    input  logic pclk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q_r;

    // One cycle of input history
    always_ff @(posedge pclk) begin
        if (rst) begin
            d_q_r <= 1'b0;
        end else begin
            d_q_r <= d;
        end
    end

    assign rise = d & ~d_q_r;

endmodule

// File: rtl/hp_bar_ctrl.sv
// Player HP state machine with an HP-bar overlay inserted into the VGA chain.
// Timing and pixel data pass through one register stage.
module hp_bar_ctrl
    import hp_pkg::*;
#(
    parameter int MAX_HP      = 5,
    parameter int HP_W        = 4,
    parameter int SEG_W       = 60,
    parameter int BAR_LEFT    = 361,
    parameter int BAR_TOP     = 737,
    parameter int BAR_H       = 50,
    parameter int BORDER      = 10,
    parameter int IFRAMES     = 60,
    parameter int FLASH_SHIFT = 3
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            game_on,
    input  logic            hit,
    input  logic [HP_W-1:0] dmg,
    input  logic            heal,
    input  logic [11:0]     hcount_in,
    input  logic [11:0]     vcount_in,
    input  logic            hsync_in,
    input  logic            vsync_in,
    input  logic            hblnk_in,
    input  logic            vblnk_in,
    input  logic [11:0]     rgb_in,
    output logic [11:0]     hcount_out,
    output logic [11:0]     vcount_out,
    output logic            hsync_out,
    output logic            vsync_out,
    output logic            hblnk_out,
    output logic            vblnk_out,
    output logic [11:0]     rgb_out,
    output logic [HP_W-1:0] hp,
    output logic            invuln,
    output logic            game_over
);

    localparam int IF_W = $clog2(IFRAMES + 1);
    localparam int FC_W = FLASH_SHIFT + 1;

    localparam logic [HP_W-1:0]   MAX_HP_V  = HP_W'(MAX_HP);
    localparam logic [HP_W+1:0]   MAX_HP_X  = (HP_W+2)'(MAX_HP);
    localparam logic [HP_W-1:0]   HP_ONE    = HP_W'(1);
    localparam logic [IF_W-1:0]   IFRAMES_V = IF_W'(IFRAMES);
    localparam logic [IF_W-1:0]   IF_ONE    = IF_W'(1);
    localparam logic [FC_W-1:0]   FC_ONE    = FC_W'(1);

    localparam logic [11:0] X_FILL_L = 12'(BAR_LEFT);
    localparam logic [11:0] X_FILL_R = 12'(BAR_LEFT + MAX_HP * SEG_W);
    localparam logic [11:0] Y_FILL_T = 12'(BAR_TOP);
    localparam logic [11:0] Y_FILL_B = 12'(BAR_TOP + BAR_H);
    localparam logic [11:0] X_FRM_L  = 12'(BAR_LEFT - BORDER);
    localparam logic [11:0] X_FRM_R  = 12'(BAR_LEFT + MAX_HP * SEG_W + BORDER);
    localparam logic [11:0] Y_FRM_T  = 12'(BAR_TOP - BORDER);
    localparam logic [11:0] Y_FRM_B  = 12'(BAR_TOP + BAR_H + BORDER);
    localparam logic [11:0] SEG_W_V  = 12'(SEG_W);

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        logic [HP_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[HP_W] ? '0 : diff[HP_W-1:0];
    endfunction

    logic hit_rise_s, heal_rise_s, game_on_rise_s, vsync_rise_s;

    hp_edge_det u_hit_edge   (.pclk(pclk), .rst(rst), .d(hit),      .rise(hit_rise_s));
    hp_edge_det u_heal_edge  (.pclk(pclk), .rst(rst), .d(heal),     .rise(heal_rise_s));
    hp_edge_det u_game_edge  (.pclk(pclk), .rst(rst), .d(game_on),  .rise(game_on_rise_s));
    hp_edge_det u_vsync_edge (.pclk(pclk), .rst(rst), .d(vsync_in), .rise(vsync_rise_s));

    hp_state_t       state_r, state_s;
    logic [HP_W-1:0] hp_r, hp_s;
    logic [IF_W-1:0] iframe_r, iframe_s;
    logic [FC_W-1:0] frame_cnt_r;
    logic [HP_W-1:0] hp_sub_s, hp_inc_s;

    assign hp_sub_s = sat_sub(hp_r, dmg);
    assign hp_inc_s = (hp_r >= MAX_HP_V) ? MAX_HP_V : (hp_r + HP_ONE);

    // Next-state, next-hp and i-frame counter; game_on low overrides everything
    always_comb begin
        state_s  = state_r;
        hp_s     = hp_r;
        iframe_s = iframe_r;
        if (!game_on) begin
            state_s  = ST_IDLE;
            hp_s     = MAX_HP_V;
            iframe_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hp_s = MAX_HP_V;
                    if (game_on_rise_s) begin
                        state_s = ST_ALIVE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ALIVE: begin
                    // A real hit wins over a coincident heal
                    if (hit_rise_s && (dmg != '0)) begin
                        hp_s = hp_sub_s;
                        if (hp_sub_s == '0) begin
                            state_s = ST_DEAD;
                        end else begin
                            state_s  = ST_INVULN;
                            iframe_s = IFRAMES_V;
                        end
                    end else if (heal_rise_s) begin
                        hp_s = hp_inc_s;
                    end else begin
                        hp_s = hp_r;
                    end
                end
                ST_INVULN: begin
                    if (heal_rise_s) begin
                        hp_s = hp_inc_s;
                    end else begin
                        hp_s = hp_r;
                    end
                    if (vsync_rise_s) begin
                        if (iframe_r == IF_ONE) begin
                            state_s  = ST_ALIVE;
                            iframe_s = '0;
                        end else begin
                            iframe_s = iframe_r - IF_ONE;
                        end
                    end else begin
                        iframe_s = iframe_r;
                    end
                end
                ST_DEAD: begin
                    hp_s    = '0;
                    state_s = ST_DEAD;
                end
                default: begin
                    state_s  = ST_IDLE;
                    hp_s     = MAX_HP_V;
                    iframe_s = '0;
                end
            endcase
        end
    end

    // FSM, hp, frame counter and status flag registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hp_r        <= MAX_HP_V;
            iframe_r    <= '0;
            frame_cnt_r <= '0;
            invuln      <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_r  <= state_s;
            hp_r     <= hp_s;
            iframe_r <= iframe_s;
            if (vsync_rise_s) begin
                frame_cnt_r <= frame_cnt_r + FC_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            invuln    <= (state_s == ST_INVULN);
            game_over <= (state_s == ST_DEAD);
        end
    end

    assign hp = hp_r;

    logic [11:0]   fill_x_s, fill_end_s, rgb_s;
    logic [HP_W+1:0] hp3_s;
    logic          in_fill_s, in_outer_s, lit_s, flash_off_s;

    assign fill_x_s    = 12'(hp_r) * SEG_W_V;
    assign fill_end_s  = X_FILL_L + fill_x_s;
    assign hp3_s       = {2'b00, hp_r} + {1'b0, hp_r, 1'b0};
    assign in_fill_s   = (hcount_in >= X_FILL_L) && (hcount_in < X_FILL_R) &&
                         (vcount_in >= Y_FILL_T) && (vcount_in < Y_FILL_B);
    assign in_outer_s  = (hcount_in >= X_FRM_L) && (hcount_in < X_FRM_R) &&
                         (vcount_in >= Y_FRM_T) && (vcount_in < Y_FRM_B);
    assign lit_s       = (hcount_in < fill_end_s);
    assign flash_off_s = (state_r == ST_INVULN) && frame_cnt_r[FLASH_SHIFT];

    // Overlay colour for the current pixel from registered hp/state
    always_comb begin
        rgb_s = rgb_in;
        if ((state_r != ST_IDLE) && !hblnk_in && !vblnk_in) begin
            if (in_outer_s && !in_fill_s) begin
                rgb_s = COL_FRAME;
            end else if (in_fill_s) begin
                if ((state_r == ST_DEAD) || flash_off_s || !lit_s) begin
                    rgb_s = COL_EMPTY;
                end else if (hp3_s > MAX_HP_X) begin
                    rgb_s = COL_OK;
                end else begin
                    rgb_s = COL_LOW;
                end
            end else begin
                rgb_s = rgb_in;
            end
        end else begin
            rgb_s = rgb_in;
        end
    end

    // One-cycle video pipeline stage
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= 12'd0;
            vcount_out <= 12'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_s;
        end
    end

endmodule

// File: tb/tb_hp_bar_ctrl.sv
// Directed scoreboard bench for hp_bar_ctrl with default parameters.
module tb_hp_bar_ctrl;

    logic        pclk = 1'b0;
    logic        rst, game_on, hit, heal;
    logic [3:0]  dmg;
    logic [11:0] hcount_in, vcount_in, rgb_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [3:0]  hp;
    logic        invuln, game_over;

    hp_bar_ctrl dut (
        .pclk(pclk), .rst(rst), .game_on(game_on), .hit(hit), .dmg(dmg), .heal(heal),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .hp(hp), .invuln(invuln), .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    localparam int K_RGB = 0, K_HP = 1, K_INV = 2, K_GO = 3, K_HS = 4,
                   K_VS = 5, K_HB = 6, K_HC = 7, K_VC = 8;

    typedef struct {
        string       tag;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   m_st    = 0;   // 0 idle, 1 alive, 2 invuln, 3 dead
    int   m_hp    = 5;
    int   fcnt    = 0;
    int   f0;

    task automatic push(input string tag, input int kind, input logic [15:0] e);
        exp_t it;
        it.tag  = tag;
        it.kind = kind;
        it.exp  = e;
        sbq.push_back(it);
    endtask

    task automatic push_status(input string tag, input int ehp, input bit einv, input bit ego);
        push({tag, "_hp"}, K_HP, 16'(ehp));
        push({tag, "_invuln"}, K_INV, {15'd0, einv});
        push({tag, "_game_over"}, K_GO, {15'd0, ego});
    endtask

    // Advance one clock, then compare every pending expectation
    task automatic tick();
        exp_t        it;
        logic [15:0] obs;
        @(posedge pclk);
        #1;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            case (it.kind)
                K_RGB:   obs = {4'd0, rgb_out};
                K_HP:    obs = {12'd0, hp};
                K_INV:   obs = {15'd0, invuln};
                K_GO:    obs = {15'd0, game_over};
                K_HS:    obs = {15'd0, hsync_out};
                K_VS:    obs = {15'd0, vsync_out};
                K_HB:    obs = {15'd0, hblnk_out};
                K_HC:    obs = {4'd0, hcount_out};
                K_VC:    obs = {4'd0, vcount_out};
                default: obs = 16'hxxxx;
            endcase
            n_total++;
            assert (obs === it.exp) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
        end
    endtask

    function automatic logic [11:0] ref_pix(input int x, input int y, input logic [11:0] rin,
                                            input logic hb, input logic vb);
        bit infill, inouter;
        if (m_st == 0 || hb || vb) return rin;
        infill  = (x >= 361) && (x < 661) && (y >= 737) && (y < 787);
        inouter = (x >= 351) && (x < 671) && (y >= 727) && (y < 797);
        if (inouter && !infill) return 12'hfff;
        if (!infill) return rin;
        if (m_st == 3) return 12'h333;
        if (m_st == 2 && fcnt[3]) return 12'h333;
        if (x < 361 + m_hp * 60) return (3 * m_hp > 5) ? 12'h0f0 : 12'hf00;
        return 12'h333;
    endfunction

    task automatic scan(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            hcount_in = 12'(x);
            vcount_in = 12'(y);
            rgb_in    = 12'h5a5;
            push($sformatf("pix_y%0d_x%0d", y, x), K_RGB,
                 {4'd0, ref_pix(x, y, rgb_in, hblnk_in, vblnk_in)});
            tick();
        end
        hcount_in = 12'd0;
        vcount_in = 12'd0;
    endtask

    task automatic frame_tick();
        vsync_in = 1'b1;
        tick();
        fcnt++;
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic do_hit(input logic [3:0] d, input int ehp, input bit einv, input bit ego,
                          input string tag);
        hit = 1'b1;
        dmg = d;
        push_status(tag, ehp, einv, ego);
        tick();
        hit = 1'b0;
        tick();
    endtask

    task automatic do_heal(input int ehp, input bit einv, input bit ego, input string tag);
        heal = 1'b1;
        push_status(tag, ehp, einv, ego);
        tick();
        heal = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; game_on = 1'b0; hit = 1'b0; heal = 1'b0; dmg = 4'd0;
        hcount_in = 12'd0; vcount_in = 12'd0; rgb_in = 12'habc;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;

        // reset state
        push("rst_rgb", K_RGB, 16'h0000);
        push("rst_hcount", K_HC, 16'h0000);
        push_status("rst", 5, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // IDLE: no overlay even inside the bar
        hcount_in = 12'd400; vcount_in = 12'd760; rgb_in = 12'h5a5;
        push("idle_pass", K_RGB, 16'h05a5);
        tick();

        game_on = 1'b1;
        push_status("start", 5, 1'b0, 1'b0);
        tick();
        m_st = 1;
        do_heal(5, 1'b0, 1'b0, "heal_at_max");
        do_hit(4'd0, 5, 1'b0, 1'b0, "hit_dmg0");

        scan(737, 349, 672);
        scan(786, 355, 365);
        scan(727, 349, 672);
        scan(736, 349, 360);
        scan(787, 660, 672);
        scan(796, 349, 672);
        scan(726, 350, 352);
        scan(797, 350, 352);

        // hit, i-frames, ignored second hit, recovery
        do_hit(4'd1, 4, 1'b1, 1'b0, "hit1");
        m_st = 2; m_hp = 4;
        repeat (10) frame_tick();
        do_hit(4'd1, 4, 1'b1, 1'b0, "hit_ignored");
        repeat (49) frame_tick();
        push("invuln_59", K_INV, 16'd1);
        tick();
        frame_tick();
        push_status("invuln_end", 4, 1'b0, 1'b0);
        tick();
        m_st = 1;
        do_hit(4'd1, 3, 1'b1, 1'b0, "hit2");
        m_st = 2; m_hp = 3;
        repeat (60) frame_tick();
        push("invuln_end2", K_INV, 16'd0);
        tick();
        m_st = 1;

        // hit and heal together in ALIVE: hit wins
        hit = 1'b1; heal = 1'b1; dmg = 4'd1;
        push_status("hit_heal", 2, 1'b1, 1'b0);
        tick();
        hit = 1'b0; heal = 1'b0;
        tick();
        m_st = 2; m_hp = 2;
        do_heal(3, 1'b1, 1'b0, "heal_invuln");
        m_hp = 3;

        // game_on dropped mid-INVULN
        hcount_in = 12'd400; vcount_in = 12'd760; rgb_in = 12'h5a5; game_on = 1'b0;
        push("drop_pix", K_RGB, {4'd0, ref_pix(400, 760, 12'h5a5, 1'b0, 1'b0)});
        push_status("drop", 5, 1'b0, 1'b0);
        tick();
        m_st = 0; m_hp = 5;
        hcount_in = 12'd401; vcount_in = 12'd761; rgb_in = 12'h7c3;
        hsync_in = 1'b1; hblnk_in = 1'b1;
        push("idle_rgb", K_RGB, 16'h07c3);
        push("hsync_dly", K_HS, 16'd1);
        push("hblnk_dly", K_HB, 16'd1);
        push("hcount_dly", K_HC, 16'd401);
        push("vcount_dly", K_VC, 16'd761);
        tick();
        hsync_in = 1'b0; hblnk_in = 1'b0;
        vsync_in = 1'b1;
        push("vsync_dly1", K_VS, 16'd1);
        tick();
        fcnt++;
        vsync_in = 1'b0;
        push("vsync_dly0", K_VS, 16'd0);
        push("hsync_dly0", K_HS, 16'd0);
        tick();
        game_on = 1'b1;
        push_status("restart", 5, 1'b0, 1'b0);
        tick();
        m_st = 1;

        // low HP colour and flashing
        do_hit(4'd4, 1, 1'b1, 1'b0, "hit4");
        m_st = 2; m_hp = 1; f0 = fcnt;
        for (int i = 0; i < 16 && fcnt[3] == 1'b0; i++) frame_tick();
        scan(760, 355, 425);
        for (int i = 0; i < 16 && fcnt[3] == 1'b1; i++) frame_tick();
        scan(760, 355, 425);
        for (int i = 0; i < 70 && (fcnt - f0) < 60; i++) frame_tick();
        push("invuln_end3", K_INV, 16'd0);
        tick();
        m_st = 1;
        scan(760, 355, 665);
        hblnk_in = 1'b1;
        scan(760, 399, 401);
        hblnk_in = 1'b0;
        vblnk_in = 1'b1;
        scan(760, 399, 401);
        vblnk_in = 1'b0;

        // death
        do_heal(2, 1'b0, 1'b0, "heal_to2");
        m_hp = 2;
        scan(760, 398, 402);
        do_hit(4'd7, 0, 1'b0, 1'b1, "hit7_dead");
        m_st = 3; m_hp = 0;
        scan(760, 355, 365);
        do_heal(0, 1'b0, 1'b1, "heal_dead");
        do_hit(4'd1, 0, 1'b0, 1'b1, "hit_dead");
        game_on = 1'b0;
        push_status("dead_drop", 5, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
